ctrl_bubble_pipe_reg: RTL and testbench
=======================================

Name: ctrl_bubble_pipe_reg

Overview:
- ID/EX control-bundle pipeline register with integrated hazard sequencing.
- Registers the decoded control bundle into EX. Detects load-use hazards against the EX-stage load and holds the front end.
- Inserts a parametrised number of zeroed bubble cycles for load-use hazards and for branch/jump flushes.
- Freezes completely on an external stall.
- Replaces the purely combinational control-zeroing mux in the RISC-V pipeline.

Parameters:
- CTRL_W, 24, width of the control bundle (load, RF enable, RAM enable/RW/SE/size, jump/JALR/JAL/AUIPC, ALU op, shift_imm, op/funct).
- BUBBLE_VALUE, {CTRL_W{1'b0}}, bundle value driven into EX on a bubble.
- LU_BUBBLES, 1, bubble cycles per load-use hazard (1..7).
- FLUSH_DEPTH, 1, bubble cycles per accepted flush (1..7).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_ctrl_in  in  CTRL_W  decoded control bundle from ID
- id_valid  in  1  ID holds a real instruction
- id_rd  in  5  ID destination register
- id_rs1, id_rs2  in  5 each  ID source registers
- id_uses_rs1, id_uses_rs2  in  1 each  source actually read
- flush_in  in  1  branch/jump taken, redirect front end
- ext_stall  in  1  downstream stall (memory busy)
- ex_ctrl_out  out  CTRL_W  registered EX control bundle
- ex_valid  out  1  EX holds a real instruction
- ex_rd  out  5  registered destination
- ex_load  out  1  registered load flag (bundle load bit, index 0)
- front_hold  out  1  combinational: hold PC and IF/ID
- front_flush  out  1  combinational: clear IF/ID
- bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset values: ex_ctrl_out=BUBBLE_VALUE, ex_valid=0, ex_rd=0, ex_load=0, bubble_count=0, state=RUN, cnt=0. front_hold and front_flush are 0 while reset=1. Reset mid-sequence aborts any LU_STALL/FLUSH.
- Load: ex_ctrl_out<=id_ctrl_in, ex_valid<=id_valid, ex_rd<=id_rd, ex_load<=id_ctrl_in[0]&id_valid.
- Bubble: ex_ctrl_out<=BUBBLE_VALUE, ex_valid<=0, ex_rd<=0, ex_load<=0, bubble_count+=1, saturating at all-ones.
- Hold: all registers, state, cnt and bubble_count unchanged.
- lu_hit = id_valid & ex_valid & ex_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Per-cycle priority: reset > ext_stall > flush_in > hazard > normal.
- ext_stall=1, any state: Hold; front_hold=1; front_flush=0; flush_in and lu_hit ignored that cycle.
- FSM, state RUN:
  - flush_in: Bubble; front_flush=1; front_hold=0; if FLUSH_DEPTH>1 -> FLUSH with cnt=FLUSH_DEPTH-1, else stay RUN.
  - lu_hit: Bubble; front_hold=1; if LU_BUBBLES>1 -> LU_STALL with cnt=LU_BUBBLES-1, else stay RUN.
  - otherwise: Load.
- FSM, state LU_STALL:
  - flush_in: handled exactly as the RUN flush case; the hazard is abandoned.
  - otherwise: Bubble; front_hold=1; cnt-=1; when cnt==1 before decrement -> RUN.
  - lu_hit is not re-evaluated.
- FSM, state FLUSH:
  - Bubble every cycle; front_flush=1; front_hold=0.
  - A new flush_in reloads cnt=FLUSH_DEPTH-1 without an extra idle cycle. If FLUSH_DEPTH==1, the reload leaves cnt=0 and the FSM returns to RUN.
  - Otherwise cnt-=1; at cnt==1 -> RUN.
- Latency: ID->EX is exactly one cycle when there is no hazard or stall.
- Load-use latency: the instruction waiting in ID reaches EX LU_BUBBLES+1 cycles after the hazard is first detected.
- In RUN the cycle after a single load-use bubble needs no special case: ex_valid=0 there, so lu_hit=0.
- ex_rd==0 never triggers a hazard.
- front_hold and front_flush are never both 1.

Test Plan:
- Reset mid-sequence: LU_BUBBLES=3, trigger hazard, assert reset on the 2nd bubble -> next cycle ex_ctrl_out=0, ex_valid=0, bubble_count=0, state RUN, front_hold=0.
- Plain flow: three back-to-back valid instructions with rd=1,2,3, no dependence -> ex_rd follows 1,2,3 one cycle later; front_hold=0; bubble_count=0.
- Load-use: EX holds load rd=5; ID add rs1=5, id_uses_rs1=1.
  - LU_BUBBLES=1 -> one bubble, front_hold=1 for one cycle, add enters EX one cycle later, bubble_count=1.
  - LU_BUBBLES=3 -> three bubbles and front_hold=1 for three cycles.
  - Same stimulus with rd=0, or with id_uses_rs1=0 -> no bubble.
- Flush: FLUSH_DEPTH=2, flush_in pulsed for one cycle -> two consecutive bubbles, front_flush=1 for both, front_hold=0, bubble_count+=2.
- Flush inside LU_STALL: LU_BUBBLES=3, flush_in on the 2nd bubble, FLUSH_DEPTH=1 -> front_hold drops to 0 that cycle, front_flush=1, the next ID instruction loads the following cycle, total bubbles=2.
- ext_stall freeze and saturation:
  - ext_stall for 4 cycles during LU_STALL with cnt=2 -> all outputs constant and front_hold=1. After release, exactly 2 more bubbles.
  - CNT_W=4, force 20 bubbles -> bubble_count holds at 15.

Source files
------------

// File: rtl/ctrl_bubble_pipe_reg.sv
// ID/EX control-bundle pipeline register with load-use and flush bubble
// sequencing. Holds the front end during load-use stalls, clears IF/ID on
// redirects, and freezes entirely while the downstream stage is stalled.
module ctrl_bubble_pipe_reg #(
  parameter int                 CTRL_W       = 24,
  parameter logic [CTRL_W-1:0]  BUBBLE_VALUE = {CTRL_W{1'b0}},
  parameter int                 LU_BUBBLES   = 1,
  parameter int                 FLUSH_DEPTH  = 1,
  parameter int                 CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  input  logic              id_valid,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              flush_in,
  input  logic              ext_stall,
  output logic [CTRL_W-1:0] ex_ctrl_out,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output logic              ex_load,
  output logic              front_hold,
  output logic              front_flush,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  // Remaining-bubble reloads; the first bubble is issued on the entry cycle.
  localparam logic [2:0] LU_RELOAD    = 3'(LU_BUBBLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       do_load, do_bubble;
  logic       rs1_hit, rs2_hit, lu_hit;

  // Saturating increment so the statistic never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu_hit  = id_valid && ex_valid && ex_load && (ex_rd != 5'd0) &&
                   (rs1_hit || rs2_hit);

  // Next-state and front-end control; stall outranks flush, flush outranks hazard.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    do_load     = 1'b0;
    do_bubble   = 1'b0;
    front_hold  = 1'b0;
    front_flush = 1'b0;
    if (reset) begin
      state_nxt = RUN;
      cnt_nxt   = 3'd0;
    end else if (ext_stall) begin
      front_hold = 1'b1;
    end else begin
      case (state)
        RUN, LU_STALL: begin
          if (flush_in) begin
            do_bubble   = 1'b1;
            front_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = FLUSH_RELOAD;
            end else begin
              state_nxt = RUN;
              cnt_nxt   = 3'd0;
            end
          end else if (state == LU_STALL) begin
            // Hazard already committed: lu_hit is not re-evaluated here.
            do_bubble  = 1'b1;
            front_hold = 1'b1;
            cnt_nxt    = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = RUN;
          end else if (lu_hit) begin
            do_bubble  = 1'b1;
            front_hold = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = LU_RELOAD;
            end
          end else begin
            do_load = 1'b1;
          end
        end
        FLUSH: begin
          do_bubble   = 1'b1;
          front_flush = 1'b1;
          if (flush_in) begin
            cnt_nxt = FLUSH_RELOAD;
            if (FLUSH_DEPTH == 1) state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- ID -> EX boundary: load, bubble or hold the control bundle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_out  <= BUBBLE_VALUE;
      ex_valid     <= 1'b0;
      ex_rd        <= 5'd0;
      ex_load      <= 1'b0;
      bubble_count <= '0;
    end else if (do_load) begin
      ex_ctrl_out <= id_ctrl_in;
      ex_valid    <= id_valid;
      ex_rd       <= id_rd;
      ex_load     <= id_ctrl_in[0] & id_valid;
    end else if (do_bubble) begin
      ex_ctrl_out  <= BUBBLE_VALUE;
      ex_valid     <= 1'b0;
      ex_rd        <= 5'd0;
      ex_load      <= 1'b0;
      bubble_count <= sat_inc(bubble_count);
    end
  end

endmodule

// File: tb/tb_ctrl_bubble_pipe_reg.sv
// Directed bench for ctrl_bubble_pipe_reg. Three instances share one
// stimulus stream: A (LU=3, FD=2), B (LU=1, FD=1), C (LU=3, FD=1, 4-bit count).
module tb_ctrl_bubble_pipe_reg;
  logic        clk = 1'b0;
  logic        reset, id_valid, id_uses_rs1, id_uses_rs2, flush_in, ext_stall;
  logic [23:0] id_ctrl_in;
  logic [4:0]  id_rd, id_rs1, id_rs2;

  logic [23:0] a_ctrl, b_ctrl, c_ctrl;
  logic        a_valid, b_valid, c_valid, a_load, b_load, c_load;
  logic [4:0]  a_rd, b_rd, c_rd;
  logic        a_hold, b_hold, c_hold, a_flush, b_flush, c_flush;
  logic [15:0] a_bc, b_bc;
  logic [3:0]  c_bc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_bubble_pipe_reg #(.CTRL_W(24), .LU_BUBBLES(3), .FLUSH_DEPTH(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_ctrl_in(id_ctrl_in), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .flush_in(flush_in), .ext_stall(ext_stall), .ex_ctrl_out(a_ctrl), .ex_valid(a_valid),
    .ex_rd(a_rd), .ex_load(a_load), .front_hold(a_hold), .front_flush(a_flush),
    .bubble_count(a_bc));

  ctrl_bubble_pipe_reg #(.CTRL_W(24), .LU_BUBBLES(1), .FLUSH_DEPTH(1), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_ctrl_in(id_ctrl_in), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .flush_in(flush_in), .ext_stall(ext_stall), .ex_ctrl_out(b_ctrl), .ex_valid(b_valid),
    .ex_rd(b_rd), .ex_load(b_load), .front_hold(b_hold), .front_flush(b_flush),
    .bubble_count(b_bc));

  ctrl_bubble_pipe_reg #(.CTRL_W(24), .LU_BUBBLES(3), .FLUSH_DEPTH(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_ctrl_in(id_ctrl_in), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .flush_in(flush_in), .ext_stall(ext_stall), .ex_ctrl_out(c_ctrl), .ex_valid(c_valid),
    .ex_rd(c_rd), .ex_load(c_load), .front_hold(c_hold), .front_flush(c_flush),
    .bubble_count(c_bc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setid(input logic v, input logic [23:0] ctrl, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2);
    id_valid = v; id_ctrl_in = ctrl; id_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush_in = 1'b0; ext_stall = 1'b0;
    setid(1'b0, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset: front outputs gated even with stall/flush asserted
    reset = 1'b1; ext_stall = 1'b1; flush_in = 1'b1;
    setid(1'b0, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_hold_a",  32'(a_hold), 32'd0);
    chk("rst_flush_a", 32'(a_flush), 32'd0);
    chk("rst_valid_a", 32'(a_valid), 32'd0);
    chk("rst_ctrl_a",  32'(a_ctrl), 32'd0);
    chk("rst_bc_a",    32'(a_bc), 32'd0);
    chk("rst_hold_c",  32'(c_hold), 32'd0);
    do_reset();

    // Plain flow rd=1,2,3 then external stall freezes EX
    setid(1'b1, 24'h000100, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("flow_hold", 32'(a_hold), 32'd0);
    tick();
    chk("flow_rd1", 32'(a_rd), 32'd1);
    chk("flow_ctrl1", 32'(a_ctrl), 32'h100);
    chk("flow_valid1", 32'(a_valid), 32'd1);
    setid(1'b1, 24'h000200, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("flow_rd2_a", 32'(a_rd), 32'd2);
    chk("flow_rd2_b", 32'(b_rd), 32'd2);
    setid(1'b1, 24'h000300, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("flow_rd3", 32'(c_rd), 32'd3);
    chk("flow_bc", 32'(a_bc), 32'd0);
    ext_stall = 1'b1;
    setid(1'b1, 24'h000400, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("stall_hold", 32'(a_hold), 32'd1);
    chk("stall_flush", 32'(a_flush), 32'd0);
    tick();
    chk("stall_rd_frozen", 32'(a_rd), 32'd3);
    ext_stall = 1'b0;
    tick();
    chk("stall_release_rd", 32'(a_rd), 32'd4);

    // Load-use: load rd=5 in EX, add rs1=5 in ID
    do_reset();
    setid(1'b1, 24'h000001, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("lu_exload", 32'(a_load), 32'd1);
    setid(1'b1, 24'h000010, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    chk("lu_hold_a0", 32'(a_hold), 32'd1);
    chk("lu_hold_b0", 32'(b_hold), 32'd1);
    tick();
    chk("lu_valid_a1", 32'(a_valid), 32'd0);
    chk("lu_bc_a1", 32'(a_bc), 32'd1);
    chk("lu_bc_b1", 32'(b_bc), 32'd1);
    chk("lu_hold_a1", 32'(a_hold), 32'd1);
    chk("lu_hold_b1", 32'(b_hold), 32'd0);
    tick();
    chk("lu_b_rd", 32'(b_rd), 32'd6);
    chk("lu_b_valid", 32'(b_valid), 32'd1);
    chk("lu_b_ctrl", 32'(b_ctrl), 32'h10);
    chk("lu_bc_a2", 32'(a_bc), 32'd2);
    chk("lu_hold_a2", 32'(a_hold), 32'd1);
    tick();
    chk("lu_bc_a3", 32'(a_bc), 32'd3);
    chk("lu_valid_a3", 32'(a_valid), 32'd0);
    chk("lu_hold_a3", 32'(a_hold), 32'd0);
    chk("lu_bc_b3", 32'(b_bc), 32'd1);
    tick();
    chk("lu_a_rd", 32'(a_rd), 32'd6);
    chk("lu_a_valid", 32'(a_valid), 32'd1);

    // No hazard when load rd=0, or when the source is not read
    do_reset();
    setid(1'b1, 24'h000001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 24'h000010, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("rd0_hold", 32'(a_hold), 32'd0);
    tick();
    chk("rd0_rd", 32'(a_rd), 32'd6);
    setid(1'b1, 24'h000001, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 24'h000010, 5'd7, 5'd5, 5'd5, 1'b0, 1'b0);
    chk("nouse_hold", 32'(a_hold), 32'd0);
    tick();
    chk("nouse_rd", 32'(a_rd), 32'd7);
    chk("nouse_bc", 32'(a_bc), 32'd0);

    // Flush pulse: A gives two bubbles, B gives one
    do_reset();
    setid(1'b1, 24'h000020, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    flush_in = 1'b1;
    #1;
    chk("fl_flush_a0", 32'(a_flush), 32'd1);
    chk("fl_hold_a0", 32'(a_hold), 32'd0);
    tick();
    flush_in = 1'b0;
    #1;
    chk("fl_valid_a1", 32'(a_valid), 32'd0);
    chk("fl_bc_a1", 32'(a_bc), 32'd1);
    chk("fl_flush_a1", 32'(a_flush), 32'd1);
    chk("fl_hold_a1", 32'(a_hold), 32'd0);
    chk("fl_flush_b1", 32'(b_flush), 32'd0);
    tick();
    chk("fl_bc_a2", 32'(a_bc), 32'd2);
    chk("fl_valid_a2", 32'(a_valid), 32'd0);
    chk("fl_flush_a2", 32'(a_flush), 32'd0);
    chk("fl_rd_b2", 32'(b_rd), 32'd7);
    tick();
    chk("fl_rd_a3", 32'(a_rd), 32'd7);
    chk("fl_bc_a3", 32'(a_bc), 32'd2);

    // Flush on 2nd load-use bubble of C (LU=3, FD=1)
    do_reset();
    setid(1'b1, 24'h000001, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 24'h000010, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    chk("lf_hold_c0", 32'(c_hold), 32'd1);
    tick();
    flush_in = 1'b1;
    #1;
    chk("lf_hold_c1", 32'(c_hold), 32'd0);
    chk("lf_flush_c1", 32'(c_flush), 32'd1);
    tick();
    flush_in = 1'b0;
    setid(1'b1, 24'h000040, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lf_bc_c2", 32'(c_bc), 32'd2);
    chk("lf_flush_c2", 32'(c_flush), 32'd0);
    chk("lf_hold_c2", 32'(c_hold), 32'd0);
    tick();
    chk("lf_rd_c3", 32'(c_rd), 32'd9);
    chk("lf_valid_c3", 32'(c_valid), 32'd1);
    chk("lf_bc_c3", 32'(c_bc), 32'd2);

    // External stall inside LU_STALL (cnt=2) on A; flush ignored while stalled
    do_reset();
    setid(1'b1, 24'h000001, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 24'h000010, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    tick();
    ext_stall = 1'b1;
    flush_in = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("xs_hold", 32'(a_hold), 32'd1);
      chk("xs_flush", 32'(a_flush), 32'd0);
      tick();
      chk("xs_bc", 32'(a_bc), 32'd1);
      chk("xs_valid", 32'(a_valid), 32'd0);
      chk("xs_ctrl", 32'(a_ctrl), 32'd0);
      if (i == 1) begin
        flush_in = 1'b0;
        #1;
      end
    end
    ext_stall = 1'b0;
    #1;
    chk("xs_rel_hold0", 32'(a_hold), 32'd1);
    tick();
    chk("xs_rel_bc1", 32'(a_bc), 32'd2);
    chk("xs_rel_hold1", 32'(a_hold), 32'd1);
    tick();
    chk("xs_rel_bc2", 32'(a_bc), 32'd3);
    chk("xs_rel_hold2", 32'(a_hold), 32'd0);
    tick();
    chk("xs_rel_rd", 32'(a_rd), 32'd6);
    chk("xs_rel_bc3", 32'(a_bc), 32'd3);

    // Reset on the 2nd load-use bubble of A
    do_reset();
    setid(1'b1, 24'h000001, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 24'h000010, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_hold_during", 32'(a_hold), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_ctrl", 32'(a_ctrl), 32'd0);
    chk("mr_valid", 32'(a_valid), 32'd0);
    chk("mr_bc", 32'(a_bc), 32'd0);
    chk("mr_hold", 32'(a_hold), 32'd0);
    tick();
    chk("mr_rd", 32'(a_rd), 32'd6);

    // Saturation: 20 flush bubbles
    do_reset();
    flush_in = 1'b1;
    repeat (20) tick();
    flush_in = 1'b0;
    #1;
    chk("sat_bc_c", 32'(c_bc), 32'd15);
    chk("sat_bc_a", 32'(a_bc), 32'd20);
    chk("sat_bc_b", 32'(b_bc), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
